enable_based_bus_sync: RTL and testbench

Enable-based multi-bit bus synchronizer, destination side.
- A source domain presents a data word and flips a request toggle.
- This block synchronizes the toggle into its single clock domain and derives a one-cycle enable from the toggle edge.
- The enable captures the quasi-static source bus into a destination register.
- Sits at the receiving edge of a clock-domain crossing for configuration/status words that change infrequently.

---
 rtl/enable_based_bus_sync_if.sv | 31 +++
 rtl/enable_based_bus_sync.sv | 67 ++++++
 tb/tb_enable_based_bus_sync.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/enable_based_bus_sync_if.sv
// Bus bundle for the enable-based synchronizer: source word + request toggle in,
// captured word, one-cycle valid pulse and transfer count out.
interface enable_based_bus_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  // Toggle protocol: every level change of i_src_req_toggle announces a new word on
  // i_src_data, held stable from before the change until it has been captured.
  // There is no back-pressure; o_data_valid pulses once per accepted word.
  logic                  i_src_req_toggle;
  logic [DATA_WIDTH-1:0] i_src_data;
  logic [DATA_WIDTH-1:0] o_dest_data;
  logic                  o_data_valid;
  logic [CNT_WIDTH-1:0]  o_xfer_count;

  modport master (
    output i_src_req_toggle,
    output i_src_data,
    input  o_dest_data,
    input  o_data_valid,
    input  o_xfer_count
  );

  modport slave (
    input  i_src_req_toggle,
    input  i_src_data,
    output o_dest_data,
    output o_data_valid,
    output o_xfer_count
  );
endinterface

// File: rtl/enable_based_bus_sync.sv
// Destination side of a toggle-request bus synchronizer: only the toggle is
// synchronized; its edge produces a one-cycle enable that captures the whole bus.
module enable_based_bus_sync #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input logic                    i_clk,
  input logic                    i_rst,
  enable_based_bus_sync_if.slave bus
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic [DATA_WIDTH-1:0]  dest_data_q, dest_data_d;
  logic                   data_valid_q, data_valid_d;
  logic [CNT_WIDTH-1:0]   xfer_count_q, xfer_count_d;
  logic                   armed;
  logic                   enable;

  assign armed  = (arm_cnt_q == ARM_DONE);
  assign enable = armed & (sync_q[SYNC_STAGES-1] ^ prev_q);

  always_comb begin
    // Only sync_q[0] sees the asynchronous toggle.
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.i_src_req_toggle};
    // prev tracks the chain even while unarmed so a level present at reset
    // release becomes the baseline instead of a spurious edge.
    prev_d       = sync_q[SYNC_STAGES-1];
    arm_cnt_d    = armed ? arm_cnt_q : arm_cnt_q + 1'b1;
    dest_data_d  = dest_data_q;
    data_valid_d = 1'b0;
    xfer_count_d = xfer_count_q;
    if (enable) begin
      dest_data_d  = bus.i_src_data;
      data_valid_d = 1'b1;
      xfer_count_d = xfer_count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q       <= '0;
      prev_q       <= 1'b0;
      arm_cnt_q    <= '0;
      dest_data_q  <= '0;
      data_valid_q <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      arm_cnt_q    <= arm_cnt_d;
      dest_data_q  <= dest_data_d;
      data_valid_q <= data_valid_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign bus.o_dest_data  = dest_data_q;
  assign bus.o_data_valid = data_valid_q;
  assign bus.o_xfer_count = xfer_count_q;

endmodule

// File: tb/tb_enable_based_bus_sync.sv
// Directed bench for enable_based_bus_sync: two instances share stimulus, the
// second with a 4-bit counter for the wrap scenario.
module tb_enable_based_bus_sync;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        src_toggle = 1'b0;
  logic [31:0] src_data = '0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  enable_based_bus_sync_if #(.DATA_WIDTH(32), .CNT_WIDTH(8)) bus0 ();
  enable_based_bus_sync_if #(.DATA_WIDTH(32), .CNT_WIDTH(4)) bus1 ();

  assign bus0.i_src_req_toggle = src_toggle;
  assign bus0.i_src_data       = src_data;
  assign bus1.i_src_req_toggle = src_toggle;
  assign bus1.i_src_data       = src_data;

  enable_based_bus_sync #(.DATA_WIDTH(32), .SYNC_STAGES(SS), .CNT_WIDTH(8)) u_dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0)
  );

  enable_based_bus_sync #(.DATA_WIDTH(32), .SYNC_STAGES(SS), .CNT_WIDTH(4)) u_dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (SS + 1) @(posedge clk);
  endtask

  // Flip the toggle with a new word and wait (bounded) for the valid pulse.
  // lat is the edge index of the pulse counting the first sampling edge as 1; 0 = timeout.
  task automatic send_word(input logic [31:0] d, output int lat);
    @(negedge clk);
    src_data   = d;
    src_toggle = ~src_toggle;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (bus0.o_data_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    src_toggle = 1'b0;
    src_data   = 32'hFFFF_FFFF;
    rst        = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({bus0.o_dest_data, bus0.o_data_valid, bus0.o_xfer_count} !== 41'd0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: data=%h valid=%b count=%0d, want 0/0/0",
                 i, bus0.o_dest_data, bus0.o_data_valid, bus0.o_xfer_count);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < SS + 1; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({bus0.o_dest_data, bus0.o_data_valid, bus0.o_xfer_count} !== 41'd0) begin
        miscompares++;
        $display("FAIL reset_release[%0d]: data=%h valid=%b count=%0d, want 0/0/0",
                 i, bus0.o_dest_data, bus0.o_data_valid, bus0.o_xfer_count);
      end
    end
  endtask

  task automatic test_single();
    int lat;
    send_word(32'h1234_5678, lat);
    vectors++;
    if (lat < 3 || lat > 4) begin
      miscompares++;
      $display("FAIL single_latency: got edge %0d, want 3 (or 4)", lat);
    end
    vectors++;
    if (bus0.o_dest_data !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL single_data: got %h want 12345678", bus0.o_dest_data);
    end
    vectors++;
    if (bus0.o_xfer_count !== 8'd1) begin
      miscompares++;
      $display("FAIL single_count: got %0d want 1", bus0.o_xfer_count);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus0.o_data_valid !== 1'b0 || bus0.o_dest_data !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL single_pulse_end: valid=%b data=%h, want 0/12345678",
               bus0.o_data_valid, bus0.o_dest_data);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_burst();
    int          lat;
    logic [31:0] d;
    logic [31:0] exp_w;
    do_reset(2);
    for (int w = 0; w < 10; w++) begin
      d = $urandom;
      exp_q.push_back(d);
      send_word(d, lat);
      exp_w = exp_q.pop_front();
      vectors++;
      if (lat == 0) begin
        miscompares++;
        $display("FAIL burst_timeout[%0d]: no valid pulse, want word %h", w, exp_w);
        continue;
      end
      vectors++;
      if (bus0.o_dest_data !== exp_w || bus0.o_xfer_count !== 8'(w + 1)) begin
        miscompares++;
        $display("FAIL burst_word[%0d]: data=%h count=%0d, want %h/%0d",
                 w, bus0.o_dest_data, bus0.o_xfer_count, exp_w, w + 1);
      end
      for (int j = lat + 1; j <= 6; j++) begin
        @(posedge clk);
        #1;
        vectors++;
        if (bus0.o_data_valid !== 1'b0 || bus0.o_dest_data !== exp_w) begin
          miscompares++;
          $display("FAIL burst_hold[%0d.%0d]: valid=%b data=%h, want 0/%h",
                   w, j, bus0.o_data_valid, bus0.o_dest_data, exp_w);
        end
      end
    end
    vectors++;
    if (bus0.o_xfer_count !== 8'd10) begin
      miscompares++;
      $display("FAIL burst_final_count: got %0d want 10", bus0.o_xfer_count);
    end
  endtask

  task automatic test_toggle_high_at_release();
    int lat;
    @(negedge clk);
    src_toggle = 1'b1;
    src_data   = 32'h0BAD_F00D;
    do_reset(3);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bus0.o_data_valid !== 1'b0 || bus0.o_xfer_count !== 8'd0) begin
        miscompares++;
        $display("FAIL toggle_high_baseline[%0d]: valid=%b count=%0d, want 0/0",
                 i, bus0.o_data_valid, bus0.o_xfer_count);
      end
    end
    send_word(32'hA5A5_A5A5, lat);
    vectors++;
    if (lat < 3 || lat > 4 || bus0.o_dest_data !== 32'hA5A5_A5A5 || bus0.o_xfer_count !== 8'd1) begin
      miscompares++;
      $display("FAIL toggle_high_next: lat=%0d data=%h count=%0d, want 3/a5a5a5a5/1",
               lat, bus0.o_dest_data, bus0.o_xfer_count);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_mid_reset();
    int          lat;
    logic [31:0] d;
    @(negedge clk);
    src_data   = 32'hDEAD_BEEF;
    src_toggle = ~src_toggle;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({bus0.o_dest_data, bus0.o_data_valid, bus0.o_xfer_count} !== 41'd0) begin
        miscompares++;
        $display("FAIL mid_reset_hold[%0d]: data=%h valid=%b count=%0d, want 0/0/0",
                 i, bus0.o_dest_data, bus0.o_data_valid, bus0.o_xfer_count);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({bus0.o_dest_data, bus0.o_data_valid, bus0.o_xfer_count} !== 41'd0) begin
        miscompares++;
        $display("FAIL mid_reset_discard[%0d]: data=%h valid=%b count=%0d, want 0/0/0",
                 i, bus0.o_dest_data, bus0.o_data_valid, bus0.o_xfer_count);
      end
    end
    for (int w = 1; w <= 10; w++) begin
      d = $urandom;
      send_word(d, lat);
      vectors++;
      if (lat == 0 || bus0.o_dest_data !== d || bus0.o_xfer_count !== 8'(w)) begin
        miscompares++;
        $display("FAIL mid_reset_xfer[%0d]: lat=%0d data=%h count=%0d, want %h/%0d",
                 w, lat, bus0.o_dest_data, bus0.o_xfer_count, d, w);
      end
      repeat (3) @(posedge clk);
    end
  endtask

  task automatic test_wrap();
    int lat;
    do_reset(2);
    for (int w = 1; w <= 17; w++) begin
      send_word(32'h100 + 32'(w), lat);
      vectors++;
      if (lat == 0 || bus1.o_xfer_count !== 4'(w % 16)) begin
        miscompares++;
        $display("FAIL wrap_count[%0d]: lat=%0d count=%0d, want %0d",
                 w, lat, bus1.o_xfer_count, w % 16);
      end
      repeat (3) @(posedge clk);
    end
    vectors++;
    if (bus1.o_dest_data !== 32'h111 || bus0.o_xfer_count !== 8'd17) begin
      miscompares++;
      $display("FAIL wrap_final: data=%h count8=%0d, want 00000111/17",
               bus1.o_dest_data, bus0.o_xfer_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_toggle_high_at_release();
    test_mid_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
